// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings, FSM state type and latched-request record for the single-transfer master.
// The package is also usable by slave models that need the same encodings.
package ahb_lite_master_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10,
      S_RESP = 2'b11
   } state_t;

   typedef struct packed {
      logic [31:0] haddr;
      logic [2:0]  hsize;
      logic        hwrite;
      logic [31:0] wdata;
   } req_t;

   // Writes return zero; a failed read returns the configured error pattern.
   function automatic logic [31:0] read_result(input logic        hwrite,
                                               input logic        hresp,
                                               input logic [31:0] hrdata,
                                               input logic [31:0] err_rdata);
      if (hwrite)
         return 32'h0;
      if (hresp == HRESP_ERROR)
         return err_rdata;
      return hrdata;
   endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// CPU-side request/response signals plus the AHB-Lite bus, bundled for the master.
// The slave modport is the environment view: it drives the request and the AHB slave responses.
interface ahb_lite_master_if;

   logic [31:0] addr;
   logic [31:0] din;
   logic        wr;
   logic [3:0]  ben;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] dout;
   logic        bus_err;

   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      input  addr, din, wr, ben,
      output addr_ok, data_ok, dout, bus_err,
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      output addr, din, wr, ben,
      input  addr_ok, data_ok, dout, bus_err,
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      output HRDATA, HREADY, HRESP
   );

endinterface

// File: rtl/ahb_size_decode.sv
// Byte-enable to HSIZE / low address bits decode. Irregular enable patterns fall back to an
// aligned word access.
module ahb_size_decode
   import ahb_lite_master_pkg::*;
(
   input  logic [3:0] ben,
   output logic [2:0] hsize,
   output logic [1:0] addr_lo
);

   always_comb begin
      hsize   = HSIZE_WORD;
      addr_lo = 2'b00;
      case (ben)
         4'b0001: begin hsize = HSIZE_BYTE; addr_lo = 2'b00; end
         4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
         4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
         4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
         4'b0011: begin hsize = HSIZE_HALF; addr_lo = 2'b00; end
         4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
         default: begin hsize = HSIZE_WORD; addr_lo = 2'b00; end
      endcase
   end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: one SINGLE transfer per CPU request, completion reported
// with a one-cycle data_ok pulse. Transfers run to completion once started.
module ahb_lite_master
   import ahb_lite_master_pkg::*;
#(
   parameter logic [3:0]  HPROT_VAL = 4'b0011,
   parameter logic [31:0] ERR_RDATA = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   ahb_lite_master_if.master bus
);

   state_t      state;
   req_t        req_d;
   logic [2:0]  dec_size;
   logic [1:0]  dec_lo;
   logic [31:0] wdata_q;

   logic [1:0]  htrans_q;
   logic [31:0] haddr_q;
   logic        hwrite_q;
   logic [2:0]  hsize_q;
   logic [31:0] hwdata_q;
   logic        data_ok_q;
   logic [31:0] dout_q;
   logic        bus_err_q;

   ahb_size_decode u_size_decode (
      .ben     (bus.ben),
      .hsize   (dec_size),
      .addr_lo (dec_lo)
   );

   always_comb begin
      req_d.haddr  = {bus.addr[31:2], dec_lo};
      req_d.hsize  = dec_size;
      req_d.hwrite = bus.wr;
      req_d.wdata  = bus.din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         htrans_q  <= HTRANS_IDLE;
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
         hsize_q   <= '0;
         hwdata_q  <= '0;
         wdata_q   <= '0;
         data_ok_q <= 1'b0;
         dout_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.ben != 4'b0000) begin
                  haddr_q  <= req_d.haddr;
                  hsize_q  <= req_d.hsize;
                  hwrite_q <= req_d.hwrite;
                  wdata_q  <= req_d.wdata;
                  htrans_q <= HTRANS_NONSEQ;
                  state    <= S_ADDR;
               end
            end
            // Address phase is held unchanged until the slave accepts it.
            S_ADDR: begin
               if (bus.HREADY) begin
                  htrans_q <= HTRANS_IDLE;
                  hwdata_q <= wdata_q;
                  state    <= S_DATA;
               end
            end
            // An ERROR response's first (HREADY=0) cycle is just another wait state here.
            S_DATA: begin
               if (bus.HREADY) begin
                  data_ok_q <= 1'b1;
                  bus_err_q <= (bus.HRESP != HRESP_OKAY);
                  dout_q    <= read_result(hwrite_q, bus.HRESP, bus.HRDATA, ERR_RDATA);
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               data_ok_q <= 1'b0;
               bus_err_q <= 1'b0;
               dout_q    <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Gated by rst so the CPU side sees "busy" for the whole reset window.
   assign bus.addr_ok = rst && (state == S_IDLE);
   assign bus.data_ok = data_ok_q;
   assign bus.dout    = dout_q;
   assign bus.bus_err = bus_err_q;

   assign bus.HADDR  = haddr_q;
   assign bus.HTRANS = htrans_q;
   assign bus.HWRITE = hwrite_q;
   assign bus.HSIZE  = hsize_q;
   assign bus.HBURST = HBURST_SINGLE;
   assign bus.HPROT  = HPROT_VAL;
   assign bus.HWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed and randomized transfers against ahb_lite_master, with a timing/decode model
// derived from byte-enable arithmetic and phase wait counts.
module tb_ahb_lite_master;
   import ahb_lite_master_pkg::*;

   localparam logic [31:0] ERR_VAL = 32'hBAD0_0BAD;

   logic        clk = 1'b0;
   logic        rst;
   int          n_chk = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;

   ahb_lite_master_if bus ();

   ahb_lite_master #(
      .HPROT_VAL (4'b0011),
      .ERR_RDATA (ERR_VAL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // Model: one set bit -> byte at that lane; the two aligned halves -> halfword; else word @0.
   function automatic logic [2:0] m_size(input logic [3:0] b);
      if ($countones(b) == 1) return 3'd0;
      if (b == 4'b0011 || b == 4'b1100) return 3'd1;
      return 3'd2;
   endfunction

   function automatic logic [1:0] m_off(input logic [3:0] b);
      if ($countones(b) == 1) return 2'($clog2(b));
      if (b == 4'b1100) return 2'd2;
      return 2'd0;
   endfunction

   task automatic idle_cycle();
      @(negedge clk);
      bus.ben = 4'b0000;
      chk("idle_addr_ok", 32'(bus.addr_ok), 32'd1);
      chk("idle_data_ok", 32'(bus.data_ok), 32'd0);
      chk("idle_dout", bus.dout, 32'd0);
      chk("idle_bus_err", 32'(bus.bus_err), 32'd0);
      chk("idle_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
   endtask

   // aw/dw: HREADY=0 cycles in address/data phase; err needs dw>=1 (two-cycle ERROR).
   task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input logic [3:0] b, input int aw, input int dw, input logic err,
                          input logic [31:0] rd, input logic junk);
      int unsigned n0;
      logic [31:0] eaddr;
      logic [31:0] edout;
      @(negedge clk);
      chk("req_addr_ok", 32'(bus.addr_ok), 32'd1);
      bus.addr = a; bus.din = d; bus.wr = w; bus.ben = b;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      n0 = cyc;
      eaddr = {a[31:2], m_off(b)};
      for (int i = 0; i <= aw; i++) begin
         @(negedge clk);
         bus.ben = junk ? 4'b0011 : 4'b0000;
         bus.addr = $urandom; bus.din = $urandom; bus.wr = ~w;
         bus.HREADY = (i == aw); bus.HRESP = 1'b0; bus.HRDATA = $urandom;
         chk("htrans_nonseq", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
         chk("haddr", bus.HADDR, eaddr);
         chk("hsize", 32'(bus.HSIZE), 32'(m_size(b)));
         chk("hwrite", 32'(bus.HWRITE), 32'(w));
         chk("addr_ok_busy", 32'(bus.addr_ok), 32'd0);
      end
      for (int j = 0; j <= dw; j++) begin
         @(negedge clk);
         bus.HREADY = (j == dw);
         bus.HRESP = err && (j >= dw - 1);
         bus.HRDATA = (j == dw) ? rd : $urandom;
         chk("htrans_data", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
         chk("haddr_data", bus.HADDR, eaddr);
         if (w) chk("hwdata", bus.HWDATA, d);
         chk("data_ok_early", 32'(bus.data_ok), 32'd0);
      end
      @(negedge clk);
      bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      edout = w ? 32'd0 : (err ? ERR_VAL : rd);
      chk("data_ok", 32'(bus.data_ok), 32'd1);
      chk("latency", cyc - n0, 32'(3 + aw + dw));
      chk("bus_err", 32'(bus.bus_err), 32'(err));
      chk("dout", bus.dout, edout);
      chk("addr_ok_resp", 32'(bus.addr_ok), 32'd0);
   endtask

   initial begin
      int aw, dw;
      logic err;
      rst = 1'b0;
      bus.addr = '0; bus.din = '0; bus.wr = 1'b0; bus.ben = 4'b0000;
      bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("rst_haddr", bus.HADDR, 32'd0);
      chk("rst_hwdata", bus.HWDATA, 32'd0);
      chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
      chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
      chk("rst_data_ok", 32'(bus.data_ok), 32'd0);
      chk("rst_dout", bus.dout, 32'd0);
      chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
      chk("rst_addr_ok", 32'(bus.addr_ok), 32'd0);
      chk("hburst", 32'(bus.HBURST), 32'd0);
      chk("hprot", 32'(bus.HPROT), 32'h3);
      rst = 1'b1;
      idle_cycle();

      // Zero-wait word read, then byte write with two data-phase waits.
      run_txn(32'h1FC0_0004, 32'h5555_5555, 1'b0, 4'b1111, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      idle_cycle();
      run_txn(32'h0000_1000, 32'h00AB_0000, 1'b1, 4'b0100, 0, 2, 1'b0, 32'h0, 1'b0);
      idle_cycle();

      // Two-cycle ERROR responses on a read and on a waited write.
      run_txn(32'h2000_0010, 32'h0, 1'b0, 4'b1111, 0, 1, 1'b1, 32'h1234_5678, 1'b0);
      idle_cycle();
      run_txn(32'h4000_0002, 32'hCAFE_F00D, 1'b1, 4'b1100, 1, 2, 1'b1, 32'h0, 1'b0);
      idle_cycle();

      // Stray ben while busy is ignored; next request lands right after data_ok.
      run_txn(32'h5000_0020, 32'h0, 1'b0, 4'b1111, 1, 1, 1'b0, 32'hA5A5_0F0F, 1'b1);
      run_txn(32'h5000_0031, 32'h0000_7700, 1'b1, 4'b0010, 0, 0, 1'b0, 32'h0, 1'b0);
      idle_cycle();

      // Reset during address phase drops HTRANS without waiting for a clock.
      @(negedge clk);
      bus.addr = 32'h3000_0008; bus.wr = 1'b0; bus.ben = 4'b1111; bus.HREADY = 1'b1;
      @(negedge clk);
      bus.ben = 4'b0000; bus.HREADY = 1'b0;
      chk("pre_rst_nonseq", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
      rst = 1'b0;
      #1;
      chk("rst_addr_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
      chk("rst_addr_haddr", bus.HADDR, 32'd0);
      chk("rst_addr_addr_ok", 32'(bus.addr_ok), 32'd0);
      @(negedge clk);
      rst = 1'b1; bus.HREADY = 1'b1;
      repeat (2) idle_cycle();

      // Reset during data phase: no completion after release.
      @(negedge clk);
      bus.addr = 32'h3000_000C; bus.wr = 1'b0; bus.ben = 4'b1111; bus.HREADY = 1'b1;
      @(negedge clk);
      bus.ben = 4'b0000; bus.HREADY = 1'b1;
      @(negedge clk);
      bus.HREADY = 1'b0;
      chk("pre_rst_addr_ok", 32'(bus.addr_ok), 32'd0);
      chk("pre_rst_haddr", bus.HADDR, 32'h3000_000C);
      rst = 1'b0;
      #1;
      chk("rst_data_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
      chk("rst_data_addr_ok", 32'(bus.addr_ok), 32'd0);
      chk("rst_data_haddr", bus.HADDR, 32'd0);
      @(negedge clk);
      rst = 1'b1; bus.HREADY = 1'b1;
      repeat (4) idle_cycle();

      // Every nonzero byte-enable code, back to back.
      for (int b = 1; b < 16; b++)
         run_txn($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(b), 0, 0, 1'b0, $urandom, 1'b0);
      idle_cycle();

      // Randomized mix of sizes, directions, waits and errors.
      for (int k = 0; k < 60; k++) begin
         aw = $urandom_range(0, 2);
         dw = $urandom_range(0, 3);
         err = (dw >= 1) && ($urandom_range(0, 3) == 0);
         run_txn($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 aw, dw, err, $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
